// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: Writeback has priority, MDU results wait in a small FIFO,
// and a starvation counter forces a one-cycle stall so that a queued MDU result can drain.
module regwrite_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wb_arb_en,
  input  logic [ADDR_W-1:0] wb_arb_addr,
  input  logic [DATA_W-1:0] wb_arb_data,
  input  logic              mdu_arb_valid,
  input  logic [ADDR_W-1:0] mdu_arb_addr,
  input  logic [DATA_W-1:0] mdu_arb_data,
  output logic              mdu_arb_ready,
  output logic              arb_stall,
  output logic              arb_pending,
  output logic              reg_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  SMAX_C  = SC_W'(STARVE_MAX);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              reg_en_q, reg_en_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_data_q, reg_data_d;

  logic              push_s;
  logic              pop_s;
  logic              wb_req_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  assign mdu_arb_ready = (count_q < DEPTH_C);
  assign arb_pending   = (count_q != {CNT_W{1'b0}});
  assign arb_stall     = (starve_cnt_q == SMAX_C);
  assign push_s        = mdu_arb_valid && mdu_arb_ready;
  assign wb_req_s      = wb_arb_en && (wb_arb_addr != {ADDR_W{1'b0}});
  assign head_addr_s   = fifo_addr_q[rd_ptr_q];
  assign head_data_s   = fifo_data_q[rd_ptr_q];

  assign reg_en   = reg_en_q;
  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;

  // Grant selection; a popped head aimed at register 0 is consumed without a write.
  always_comb begin
    pop_s        = 1'b0;
    starve_cnt_d = {SC_W{1'b0}};
    reg_en_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_data_d   = reg_data_q;
    if (arb_stall || (!wb_req_s && arb_pending)) begin
      pop_s      = arb_pending;
      reg_en_d   = arb_pending && (head_addr_s != {ADDR_W{1'b0}});
      reg_addr_d = head_addr_s;
      reg_data_d = head_data_s;
    end else if (wb_req_s) begin
      reg_en_d   = 1'b1;
      reg_addr_d = wb_arb_addr;
      reg_data_d = wb_arb_data;
      if (arb_pending && (starve_cnt_q != SMAX_C)) begin
        starve_cnt_d = starve_cnt_q + SC_W'(1);
      end else if (arb_pending) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = {SC_W{1'b0}};
      end
    end else begin
      starve_cnt_d = {SC_W{1'b0}};
    end
  end

  // FIFO storage, pointers and occupancy; a pushed entry only becomes the head next cycle.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push_s) begin
      fifo_addr_d[wr_ptr_q] = mdu_arb_addr;
      fifo_data_d[wr_ptr_q] = mdu_arb_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fifo_addr_q  <= '{default: {ADDR_W{1'b0}}};
      fifo_data_q  <= '{default: {DATA_W{1'b0}}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      starve_cnt_q <= {SC_W{1'b0}};
      reg_en_q     <= 1'b0;
      reg_addr_q   <= {ADDR_W{1'b0}};
      reg_data_q   <= {DATA_W{1'b0}};
    end else begin
      fifo_addr_q  <= fifo_addr_d;
      fifo_data_q  <= fifo_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      reg_en_q     <= reg_en_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: a queue-based reference model predicts every cycle's
// register-file write, which is queued and compared once the DUT has registered it.
module tb_regwrite_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_arb_en = 1'b0;
  logic [4:0]  wb_arb_addr = 5'd0;
  logic [31:0] wb_arb_data = 32'd0;
  logic        mdu_arb_valid = 1'b0;
  logic [4:0]  mdu_arb_addr = 5'd0;
  logic [31:0] mdu_arb_data = 32'd0;
  logic        mdu_arb_ready, arb_stall, arb_pending, reg_en;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;

  regwrite_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_arb_en(wb_arb_en), .wb_arb_addr(wb_arb_addr), .wb_arb_data(wb_arb_data),
    .mdu_arb_valid(mdu_arb_valid), .mdu_arb_addr(mdu_arb_addr), .mdu_arb_data(mdu_arb_data),
    .mdu_arb_ready(mdu_arb_ready), .arb_stall(arb_stall), .arb_pending(arb_pending),
    .reg_en(reg_en), .reg_addr(reg_addr), .reg_data(reg_data)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  typedef struct { logic en; logic [4:0] addr; logic [31:0] data; logic chk_ad; } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   m_starve = 0;
  bit   m_known = 1'b0;
  bit   m_last_push = 1'b0;
  bit   m_last_stall = 1'b0;
  int   stall_seen = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check flag outputs, predict and then check the write.
  task automatic step(input logic rn, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
    exp_t e;
    ent_t h;
    bit   push;
    @(negedge clock);
    reset_n = rn; wb_arb_en = we; wb_arb_addr = wa; wb_arb_data = wd;
    mdu_arb_valid = mv; mdu_arb_addr = ma; mdu_arb_data = md;
    #1;
    m_last_stall = m_known && (m_starve == SMAX);
    if (m_known) begin
      chk("ready", mdu_arb_ready, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
      chk("stall", arb_stall, m_last_stall ? 32'd1 : 32'd0);
      chk("pending", arb_pending, (mq.size() != 0) ? 32'd1 : 32'd0);
    end
    if (arb_stall === 1'b1) stall_seen++;
    e = '{en: 1'b0, addr: 5'd0, data: 32'd0, chk_ad: 1'b0};
    m_last_push = 1'b0;
    if (!rn) begin
      mq.delete();
      m_starve = 0;
      m_known = 1'b1;
      e.chk_ad = 1'b1;
    end else begin
      push = mv && (mq.size() < DEPTH);
      if (m_starve == SMAX || (!(we && wa != 5'd0) && mq.size() != 0)) begin
        h = mq.pop_front();
        e.en = (h.a != 5'd0); e.addr = h.a; e.data = h.d; e.chk_ad = e.en;
        m_starve = 0;
      end else if (we && wa != 5'd0) begin
        e.en = 1'b1; e.addr = wa; e.data = wd; e.chk_ad = 1'b1;
        if (mq.size() == 0) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
      end else begin
        m_starve = 0;
      end
      if (push) mq.push_back('{a: ma, d: md});
      m_last_push = push;
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("reg_en", reg_en, {31'd0, e.en});
    if (e.chk_ad) begin
      chk("reg_addr", reg_addr, {27'd0, e.addr});
      chk("reg_data", reg_data, e.data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int k;
    int guard;
    // Reset with every input active
    step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd9, 32'h2222_2222);
    step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd9, 32'h2222_2222);
    chk("rst_ready", mdu_arb_ready, 32'd1);
    chk("rst_pending", arb_pending, 32'd0);
    idle(1);

    // Writeback only, then a Writeback to register 0
    step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    idle(1);
    step(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    idle(1);

    // MDU result into an idle port, then one aimed at register 0
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_1234);
    chk("t3_pending", arb_pending, 32'd1);
    idle(1);
    chk("t3_pending_clr", arb_pending, 32'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_5678);
    idle(2);

    // Back-pressure: Writeback busy, three MDU results offered back to back
    step(1'b1, 1'b1, 5'd3, 32'hA000_0000, 1'b1, 5'd10, 32'h0000_0100);
    step(1'b1, 1'b1, 5'd4, 32'hA000_0001, 1'b1, 5'd11, 32'h0000_0101);
    chk("t4_ready_full", mdu_arb_ready, 32'd0);
    k = 2;
    guard = 0;
    do begin
      step(1'b1, 1'b1, 5'd5, 32'hA000_0000 + k, 1'b1, 5'd12, 32'h0000_0102);
      k++;
      guard++;
    end while (!m_last_push && guard < 20);
    chk("t4_third_accepted", {31'd0, m_last_push}, 32'd1);
    idle(4);

    // Starvation: one queued MDU entry against continuous Writeback traffic
    stall_seen = 0;
    step(1'b1, 1'b1, 5'd7, 32'h5000_0000, 1'b1, 5'd13, 32'h0000_0CAF);
    k = 1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 5'd7, 32'h5000_0000 + k, 1'b0, 5'd0, 32'd0);
      if (!m_last_stall) k++;
    end
    chk("t5_one_stall", stall_seen, 32'd1);
    chk("t5_stall_clear", arb_stall, 32'd0);
    idle(1);

    // Reset with the FIFO full: buffered results must vanish
    step(1'b1, 1'b1, 5'd6, 32'h6000_0000, 1'b1, 5'd14, 32'h0000_0E00);
    step(1'b1, 1'b1, 5'd6, 32'h6000_0001, 1'b1, 5'd15, 32'h0000_0F00);
    chk("t6_full", mdu_arb_ready, 32'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t6_pending", arb_pending, 32'd0);
    idle(4);

    // Mixed pseudo-random traffic
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
